// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited requests to a variable-latency
// instruction memory, buffers in-order responses and presents the head entry to decode.
module fetch_unit #(
  parameter int                         ADDRESS_WIDTH = 32,
  parameter int                         DATA_WIDTH    = 32,
  parameter int                         FIFO_DEPTH    = 2,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_d,
  input  logic                     pc_src_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
  input  logic                     imem_resp_valid,
  input  logic [DATA_WIDTH-1:0]    imem_resp_data,
  output logic                     instr_valid_f,
  output logic [ADDRESS_WIDTH-1:0] pc_f,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
  output logic [DATA_WIDTH-1:0]    instr_f
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]         DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W:0]           DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0]    NOP       = DATA_WIDTH'(32'h0000_0013);
  localparam logic [ADDRESS_WIDTH-1:0] FOUR      = ADDRESS_WIDTH'(4);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN     = ~ADDRESS_WIDTH'(3);

  logic [ADDRESS_WIDTH-1:0] fetch_pc;
  logic [ADDRESS_WIDTH-1:0] resp_pc;
  logic [ADDRESS_WIDTH-1:0] pc_mem    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    instr_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W-1:0]         wr_ptr;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         outstanding;
  logic [CNT_W-1:0]         discard;
  logic                     started;

  logic [CNT_W:0]           credit_used;
  logic [CNT_W-1:0]         resp_dec;
  logic [ADDRESS_WIDTH-1:0] target_aligned;
  logic                     req_fire;
  logic                     empty;
  logic                     push;
  logic                     pop;

  // Every slot is either buffered or promised to an in-flight request, so the FIFO can't overflow.
  assign credit_used    = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = started && !pc_src_e && (credit_used < DEPTH_EXT);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_dec       = CNT_W'(imem_resp_valid);
  assign target_aligned = pc_target_e & ALIGN;
  assign empty          = (count == '0);
  assign push           = imem_resp_valid && (discard == '0) && !pc_src_e;
  assign pop            = !empty && !stall_d && !pc_src_e;

  assign instr_valid_f  = !empty;
  assign pc_f           = empty ? '0  : pc_mem[rd_ptr];
  assign instr_f        = empty ? NOP : instr_mem[rd_ptr];
  assign pc_plus4_f     = pc_f + FOUR;

  // A redirect wins over everything: flush the buffer and mark in-flight responses as stale.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      started     <= 1'b0;
    end else begin
      started <= 1'b1;
      if (pc_src_e) begin
        fetch_pc    <= target_aligned;
        resp_pc     <= target_aligned;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        count       <= '0;
        outstanding <= outstanding - resp_dec;
        discard     <= outstanding - resp_dec;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + FOUR;
        end
        outstanding <= outstanding + CNT_W'(req_fire) - resp_dec;
        if (imem_resp_valid && (discard != '0)) begin
          discard <= discard - CNT_W'(1);
        end
        if (push) begin
          wr_ptr  <= wr_ptr + PTR_W'(1);
          resp_pc <= resp_pc + FOUR;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= resp_pc;
      instr_mem[wr_ptr] <= imem_resp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push && !pop) begin
      assert (count < DEPTH_C);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-configurable memory model returns {PC} as data and a
// queue of expected PCs is checked every time decode accepts an instruction.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_d = 1'b0;
  logic        pc_src_e = 1'b0;
  logic [31:0] pc_target_e = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        instr_valid_f;
  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic [31:0] instr_f;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t    mem_q[$];
  logic [31:0] exp_q[$];
  int          lat = 1;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_d        (stall_d),
    .pc_src_e       (pc_src_e),
    .pc_target_e    (pc_target_e),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .instr_valid_f  (instr_valid_f),
    .pc_f           (pc_f),
    .pc_plus4_f     (pc_plus4_f),
    .instr_f        (instr_f)
  );

  always #5 clk = ~clk;

  // In-order memory with fixed latency; it resets together with the fetch unit.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      mem_q.delete();
      imem_resp_valid <= 1'b0;
      imem_resp_data  <= '0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mem_q.push_back('{addr: imem_req_addr, due: cyc + lat - 1});
      end
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        imem_resp_valid <= 1'b1;
        imem_resp_data  <= mem_q[0].addr;
        void'(mem_q.pop_front());
      end else begin
        imem_resp_valid <= 1'b0;
      end
    end
  end

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic refill(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 48; i++) begin
      exp_q.push_back(base + 32'(4 * i));
    end
  endtask

  // Drives the inputs for the next edge; a reset or redirect restarts the expected PC stream.
  task automatic applyStimulus(input logic rst, input logic stall, input logic src,
                               input logic [31:0] tgt, input logic ready);
    rst_n          = rst;
    stall_d        = stall;
    pc_src_e       = src;
    pc_target_e    = tgt;
    imem_req_ready = ready;
    if (!rst) begin
      refill(32'h0000_0000);
    end else if (src) begin
      refill(tgt & 32'hFFFF_FFFC);
    end
  endtask

  task automatic checkOutput();
    logic [31:0] e;
    if (rst_n && !pc_src_e && instr_valid_f && !stall_d) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      checkEq("pc_f", pc_f, e);
      checkEq("instr_f", instr_f, e);
      checkEq("pc_plus4_f", pc_plus4_f, e + 32'd4);
    end
    if (!instr_valid_f) begin
      checkEq("nop_when_idle", instr_f, 32'h0000_0013);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic runIdle();
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
    checkOutput();
  endtask

  task automatic waitPc(input string tag, input logic [31:0] target, input logic stall_on_hit);
    logic hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      hit = instr_valid_f && (pc_f == target);
      applyStimulus(1'b1, hit ? stall_on_hit : 1'b0, 1'b0, '0, 1'b1);
      checkOutput();
    end
    checkEq(tag, 32'(hit), 32'd1);
  endtask

  task automatic waitFirstReq(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = imem_req_valid;
      if (seen) begin
        checkEq(tag, imem_req_addr, 32'h0000_0000);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
      checkOutput();
    end
    checkEq({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    logic found;

    // Reset held for three edges.
    for (int i = 0; i < 3; i++) begin
      step();
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
      checkOutput();
      checkEq("reset_valid", 32'(instr_valid_f), 32'd0);
      checkEq("reset_instr", instr_f, 32'h0000_0013);
      checkEq("reset_pc", pc_f, 32'h0000_0000);
      checkEq("reset_req_valid", 32'(imem_req_valid), 32'd0);
    end
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
    checkOutput();
    checkEq("req_after_reset", 32'(imem_req_valid), 32'd0);
    waitFirstReq("first_req_addr");
    waitPc("reach_0x4", 32'h4, 1'b0);

    // Decode stall holding pc 0x8 for four cycles.
    waitPc("reach_0x8", 32'h8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      checkEq("stall_valid", 32'(instr_valid_f), 32'd1);
      checkEq("stall_pc", pc_f, 32'h8);
      if (i == 2) begin
        checkEq("stall_credit_full", 32'(imem_req_valid), 32'd0);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);
      checkOutput();
    end
    waitPc("resume_0xc", 32'hC, 1'b0);

    // Memory back-pressure on the first request seen after the stall.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = imem_req_valid && (imem_req_addr == 32'h14);
      applyStimulus(1'b1, 1'b0, 1'b0, '0, !found);
      checkOutput();
    end
    checkEq("req_0x14_seen", 32'(found), 32'd1);
    for (int i = 0; i < 2; i++) begin
      step();
      checkEq("bp_req_valid", 32'(imem_req_valid), 32'd1);
      checkEq("bp_req_addr", imem_req_addr, 32'h14);
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      checkOutput();
    end
    step();
    checkEq("bp_drained", 32'(instr_valid_f), 32'd0);
    checkEq("bp_addr_hold", imem_req_addr, 32'h14);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
    checkOutput();
    waitPc("reach_0x14", 32'h14, 1'b0);

    // Three-cycle memory, redirect with two requests in flight.
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      found = (mem_q.size() == 2);
      applyStimulus(1'b1, 1'b0, found, 32'h100, 1'b1);
      checkOutput();
    end
    checkEq("two_in_flight", 32'(found), 32'd1);
    waitPc("reach_0x100", 32'h100, 1'b0);
    waitPc("reach_0x104", 32'h104, 1'b0);

    // Redirect (under stall) as a response lands, then again to 0x200.
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      found = imem_resp_valid;
      applyStimulus(1'b1, found, found, 32'h180, 1'b1);
      checkOutput();
    end
    checkEq("resp_during_redirect", 32'(found), 32'd1);
    step();
    checkEq("flushed_after_redirect", 32'(instr_valid_f), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h200, 1'b1);
    checkOutput();
    waitPc("reach_0x200", 32'h200, 1'b0);

    // Redirect to the top of the address space with a misaligned target.
    lat = 1;
    step();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    checkOutput();
    waitPc("reach_top", 32'hFFFF_FFFC, 1'b0);
    waitPc("wrap_to_0", 32'h0, 1'b0);
    waitPc("after_wrap", 32'h4, 1'b0);

    // Mid-stream reset.
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput();
    step();
    checkEq("midreset_valid", 32'(instr_valid_f), 32'd0);
    checkEq("midreset_req", 32'(imem_req_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
    checkOutput();
    waitFirstReq("midreset_first_req");
    waitPc("midreset_pc0", 32'h0, 1'b0);
    waitPc("midreset_pc4", 32'h4, 1'b0);
    runIdle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
